// File: rtl/chacha20_block_ctrl_if.sv
// Bundle of the block controller's control, keystream and quarter-round core signals.
// The slave modport is the controller's view; the master modport is the environment's view.
interface chacha20_block_ctrl_if;
    logic         i_start;
    logic [255:0] i_key;
    logic [31:0]  i_counter;
    logic [95:0]  i_nonce;
    logic         o_busy;
    logic [511:0] o_block;
    logic         o_block_valid;
    logic [31:0]  o_qr_a;
    logic [31:0]  o_qr_b;
    logic [31:0]  o_qr_c;
    logic [31:0]  o_qr_d;
    logic         o_qr_valid;
    logic [31:0]  i_qr_a;
    logic [31:0]  i_qr_b;
    logic [31:0]  i_qr_c;
    logic [31:0]  i_qr_d;
    logic         i_qr_valid;
    logic         i_qr_busy;
    logic [2:0]   o_dbg_state;

    // Handshake: o_qr_valid is a single-cycle request issued only while i_qr_busy is low;
    // a result is taken exactly on the cycle i_qr_valid is high and the controller waits for it.
    modport slave (
        input  i_start, i_key, i_counter, i_nonce,
        input  i_qr_a, i_qr_b, i_qr_c, i_qr_d, i_qr_valid, i_qr_busy,
        output o_busy, o_block, o_block_valid,
        output o_qr_a, o_qr_b, o_qr_c, o_qr_d, o_qr_valid, o_dbg_state
    );

    modport master (
        output i_start, i_key, i_counter, i_nonce,
        output i_qr_a, i_qr_b, i_qr_c, i_qr_d, i_qr_valid, i_qr_busy,
        input  o_busy, o_block, o_block_valid,
        input  o_qr_a, o_qr_b, o_qr_c, o_qr_d, o_qr_valid, o_dbg_state
    );
endinterface

// File: rtl/chacha20_block_ctrl.sv
// ChaCha20 block-function sequencer: drives one external quarter-round core through all
// column/diagonal rounds, then adds the initial state and presents the 512-bit keystream.
module chacha20_block_ctrl #(
    parameter int DATA_WIDTH        = 32,
    parameter int NUM_DOUBLE_ROUNDS = 10
) (
    input  logic                  i_aclk,
    input  logic                  i_aresetn,
    chacha20_block_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_FINAL = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    localparam logic [3:0] LAST_DR = 4'(NUM_DOUBLE_ROUNDS - 1);
    localparam logic [DATA_WIDTH-1:0] SIGMA [4] = '{32'h61707865, 32'h3320646e,
                                                     32'h79622d32, 32'h6b206574};

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] work_q [16];
    logic [DATA_WIDTH-1:0] work_d [16];
    logic [DATA_WIDTH-1:0] init_q [16];
    logic [DATA_WIDTH-1:0] init_d [16];
    logic [511:0]          block_q, block_d;
    logic [31:0]           qr_a_q, qr_a_d, qr_b_q, qr_b_d, qr_c_q, qr_c_d, qr_d_q, qr_d_d;
    logic                  qr_valid_q, qr_valid_d;
    logic                  busy_q, busy_d;
    logic                  block_valid_q, block_valid_d;
    logic [3:0]            dr_q, dr_d;
    logic [2:0]            q_q, q_d;
    logic [3:0]            ia, ib, ic, id;

    // Quarter-round q selects four state words: columns first, then diagonals.
    always_comb begin
        case (q_q)
            3'd0:    {ia, ib, ic, id} = {4'd0, 4'd4, 4'd8,  4'd12};
            3'd1:    {ia, ib, ic, id} = {4'd1, 4'd5, 4'd9,  4'd13};
            3'd2:    {ia, ib, ic, id} = {4'd2, 4'd6, 4'd10, 4'd14};
            3'd3:    {ia, ib, ic, id} = {4'd3, 4'd7, 4'd11, 4'd15};
            3'd4:    {ia, ib, ic, id} = {4'd0, 4'd5, 4'd10, 4'd15};
            3'd5:    {ia, ib, ic, id} = {4'd1, 4'd6, 4'd11, 4'd12};
            3'd6:    {ia, ib, ic, id} = {4'd2, 4'd7, 4'd8,  4'd13};
            default: {ia, ib, ic, id} = {4'd3, 4'd4, 4'd9,  4'd14};
        endcase
    end

    always_comb begin
        state_d       = state_q;
        work_d        = work_q;
        init_d        = init_q;
        block_d       = block_q;
        qr_a_d        = qr_a_q;
        qr_b_d        = qr_b_q;
        qr_c_d        = qr_c_q;
        qr_d_d        = qr_d_q;
        qr_valid_d    = 1'b0;
        busy_d        = busy_q;
        block_valid_d = 1'b0;
        dr_d          = dr_q;
        q_d           = q_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    state_d = S_LOAD;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                for (int i = 0; i < 4; i++) init_d[i] = SIGMA[i];
                for (int k = 0; k < 8; k++) init_d[4+k] = bus.i_key[32*k +: 32];
                init_d[12] = bus.i_counter;
                for (int n = 0; n < 3; n++) init_d[13+n] = bus.i_nonce[32*n +: 32];
                work_d  = init_d;
                dr_d    = 4'd0;
                q_d     = 3'd0;
                state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!bus.i_qr_busy) begin
                    qr_a_d     = work_q[ia];
                    qr_b_d     = work_q[ib];
                    qr_c_d     = work_q[ic];
                    qr_d_d     = work_q[id];
                    qr_valid_d = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.i_qr_valid) begin
                    work_d[ia] = bus.i_qr_a;
                    work_d[ib] = bus.i_qr_b;
                    work_d[ic] = bus.i_qr_c;
                    work_d[id] = bus.i_qr_d;
                    if (q_q != 3'd7) begin
                        q_d     = q_q + 3'd1;
                        state_d = S_ISSUE;
                    end else if (dr_q != LAST_DR) begin
                        q_d     = 3'd0;
                        dr_d    = dr_q + 4'd1;
                        state_d = S_ISSUE;
                    end else begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                for (int i = 0; i < 16; i++) block_d[32*i +: 32] = work_q[i] + init_q[i];
                block_valid_d = 1'b1;
                state_d       = S_DONE;
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q       <= S_IDLE;
            for (int i = 0; i < 16; i++) begin
                work_q[i] <= '0;
                init_q[i] <= '0;
            end
            block_q       <= '0;
            qr_a_q        <= '0;
            qr_b_q        <= '0;
            qr_c_q        <= '0;
            qr_d_q        <= '0;
            qr_valid_q    <= 1'b0;
            busy_q        <= 1'b0;
            block_valid_q <= 1'b0;
            dr_q          <= '0;
            q_q           <= '0;
        end else begin
            state_q       <= state_d;
            work_q        <= work_d;
            init_q        <= init_d;
            block_q       <= block_d;
            qr_a_q        <= qr_a_d;
            qr_b_q        <= qr_b_d;
            qr_c_q        <= qr_c_d;
            qr_d_q        <= qr_d_d;
            qr_valid_q    <= qr_valid_d;
            busy_q        <= busy_d;
            block_valid_q <= block_valid_d;
            dr_q          <= dr_d;
            q_q           <= q_d;
        end
    end

    assign bus.o_busy        = busy_q;
    assign bus.o_block       = block_q;
    assign bus.o_block_valid = block_valid_q;
    assign bus.o_qr_a        = qr_a_q;
    assign bus.o_qr_b        = qr_b_q;
    assign bus.o_qr_c        = qr_c_q;
    assign bus.o_qr_d        = qr_d_q;
    assign bus.o_qr_valid    = qr_valid_q;
    assign bus.o_dbg_state   = state_q;
endmodule
